// File: rtl/i2c_dac_writer.sv
`default_nettype none
// ============================================================================
// Module   : i2c_dac_writer
// Brief    : Four-byte I2C write master for the threshold / HV DAC buses.
//            Optional macro I2C_NACK_ABORT_EN: stop the frame after a NACKed slot.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_dac_writer #(
    parameter int CLK_DIV = 30,
    parameter int NBUS    = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ENABLE,
    input  logic [NBUS-1:0] I2CLINES,
    input  logic [15:0]     I2CDATA12,
    input  logic [15:0]     I2CDATA34,
    input  logic [NBUS-1:0] SDAIN,
    output logic [NBUS-1:0] SCLLINES,
    output logic [NBUS-1:0] SDALINES,
    output logic            BUSY,
    output logic            DONE,
    output logic            NACK
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BIT   = 3'd2,
        S_ACK   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    localparam logic [15:0] c_div_last = 16'(CLK_DIV - 1);

`ifdef I2C_NACK_ABORT_EN
    localparam logic c_abort = 1'b1;
`else
    localparam logic c_abort = 1'b0;
`endif

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_step, w_step_nxt;
    logic [2:0]      r_bit_cnt, w_bit_cnt_nxt;
    logic [1:0]      r_byte_cnt, w_byte_cnt_nxt;
    logic [15:0]     r_div, w_div_nxt;
    logic [31:0]     r_shift, w_shift_nxt;
    logic [NBUS-1:0] r_lines, w_lines_nxt;
    logic            r_scl, w_scl_nxt;
    logic            r_sda, w_sda_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_done, w_done_nxt;
    logic            r_nack, w_nack_nxt;
    logic            r_en_q, r_en_prev;
    logic [NBUS-1:0] r_sdain_meta, r_sdain_sync;
    logic            w_accept;
    logic            w_tick;

    assign w_accept = (r_state == S_IDLE) && r_en_q && !r_en_prev && (|I2CLINES);
    assign w_tick   = (r_state != S_IDLE) && (r_div == c_div_last);

    // Unselected buses stay released; selected ones share one waveform.
    assign SCLLINES = {NBUS{r_scl}} | ~r_lines;
    assign SDALINES = {NBUS{r_sda}} | ~r_lines;
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign NACK     = r_nack;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= S_IDLE;
            r_step       <= 2'd0;
            r_bit_cnt    <= 3'd0;
            r_byte_cnt   <= 2'd0;
            r_div        <= 16'd0;
            r_shift      <= 32'd0;
            r_lines      <= '0;
            r_scl        <= 1'b1;
            r_sda        <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_nack       <= 1'b0;
            r_en_q       <= 1'b0;
            r_en_prev    <= 1'b0;
            r_sdain_meta <= '1;
            r_sdain_sync <= '1;
        end else begin
            r_state      <= w_state_nxt;
            r_step       <= w_step_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_div        <= w_div_nxt;
            r_shift      <= w_shift_nxt;
            r_lines      <= w_lines_nxt;
            r_scl        <= w_scl_nxt;
            r_sda        <= w_sda_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_nack       <= w_nack_nxt;
            r_en_q       <= ENABLE;
            r_en_prev    <= r_en_q;
            r_sdain_meta <= SDAIN;
            r_sdain_sync <= r_sdain_meta;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_step_nxt     = r_step;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_byte_cnt_nxt = r_byte_cnt;
        w_shift_nxt    = r_shift;
        w_lines_nxt    = r_lines;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_nack_nxt     = r_nack;
        w_div_nxt      = (r_state == S_IDLE || w_tick) ? 16'd0 : r_div + 16'd1;
        w_scl_nxt      = 1'b1;
        w_sda_nxt      = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt    = S_START;
                    w_step_nxt     = 2'd0;
                    w_bit_cnt_nxt  = 3'd0;
                    w_byte_cnt_nxt = 2'd0;
                    w_shift_nxt    = {I2CDATA12, I2CDATA34};
                    w_lines_nxt    = I2CLINES;
                    w_nack_nxt     = 1'b0;
                    w_busy_nxt     = 1'b1;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_step_nxt = r_step + 2'd1;
                    if (r_step == 2'd1) begin
                        w_state_nxt = S_BIT;
                        w_step_nxt  = 2'd0;
                    end
                end
            end
            S_BIT: begin
                if (w_tick) begin
                    w_step_nxt = r_step + 2'd1;
                    if (r_step == 2'd3) begin
                        w_shift_nxt   = {r_shift[30:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = S_ACK;
                        end
                    end
                end
            end
            S_ACK: begin
                if (w_tick) begin
                    w_step_nxt = r_step + 2'd1;
                    if (r_step == 2'd2 && (|(r_sdain_sync & r_lines))) begin
                        w_nack_nxt = 1'b1;
                    end
                    if (r_step == 2'd3) begin
                        w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3 || (c_abort && r_nack)) begin
                            w_state_nxt = S_STOP;
                        end else begin
                            w_state_nxt = S_BIT;
                        end
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_step_nxt = r_step + 2'd1;
                    if (r_step == 2'd2) begin
                        w_state_nxt = S_IDLE;
                        w_step_nxt  = 2'd0;
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_step_nxt  = 2'd0;
                w_busy_nxt  = 1'b0;
            end
        endcase

        // Line levels are decoded from the upcoming step so the pads are registered.
        case (w_state_nxt)
            S_START: begin
                w_sda_nxt = 1'b0;
                w_scl_nxt = (w_step_nxt == 2'd0);
            end
            S_BIT: begin
                w_sda_nxt = w_shift_nxt[31];
                w_scl_nxt = (w_step_nxt == 2'd1) || (w_step_nxt == 2'd2);
            end
            S_ACK: begin
                w_sda_nxt = 1'b1;
                w_scl_nxt = (w_step_nxt == 2'd1) || (w_step_nxt == 2'd2);
            end
            S_STOP: begin
                w_sda_nxt = (w_step_nxt == 2'd2);
                w_scl_nxt = (w_step_nxt != 2'd0);
            end
            default: begin
                w_sda_nxt = 1'b1;
                w_scl_nxt = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_dac_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_dac_writer
// Brief    : Self-checking bench for i2c_dac_writer with an I2C bus decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_dac_writer;

    localparam int CLK_DIV = 4;
`ifdef I2C_NACK_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic        clk_i;
    logic        rst_i;
    logic        ENABLE;
    logic [1:0]  I2CLINES;
    logic [15:0] I2CDATA12;
    logic [15:0] I2CDATA34;
    logic [1:0]  SDAIN;
    logic [1:0]  SCLLINES;
    logic [1:0]  SDALINES;
    logic        BUSY;
    logic        DONE;
    logic        NACK;

    i2c_dac_writer #(.CLK_DIV(CLK_DIV), .NBUS(2)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ENABLE    (ENABLE),
        .I2CLINES  (I2CLINES),
        .I2CDATA12 (I2CDATA12),
        .I2CDATA34 (I2CDATA34),
        .SDAIN     (SDAIN),
        .SCLLINES  (SCLLINES),
        .SDALINES  (SDALINES),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .NACK      (NACK)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic [1:0]  lines;
        logic [15:0] d12;
        logic [15:0] d34;
        logic [1:0]  sdain;
        logic        exp_nack;
        int          exp_cycles;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: NACK if any selected slave releases SDA; length by tick count.
    function automatic vec_t mk(input logic [1:0] l, input logic [15:0] a,
                                input logic [15:0] b, input logic [1:0] s);
        vec_t v;
        int   nbytes;
        v.lines    = l;
        v.d12      = a;
        v.d34      = b;
        v.sdain    = s;
        v.exp_nack = |(s & l);
        nbytes     = (ABORT && v.exp_nack) ? 1 : 4;
        v.exp_cycles = (2 + nbytes * (8 + 1) * 4 + 3) * CLK_DIV;
        return v;
    endfunction

    // Bus monitor: decodes START (-1), STOP (-2) and 9-bit words {byte, ack}.
    int         ev0[$];
    int         ev1[$];
    int         lowcnt[2];
    int         bcnt[2];
    int         word[2];
    int         diffcnt    = 0;
    int         done_cnt   = 0;
    int         busy_rise  = 0;
    int         clear_req  = 0;
    int         clr_seen   = 0;
    logic [1:0] p_scl      = 2'b11;
    logic [1:0] p_sda      = 2'b11;
    logic       p_busy     = 1'b0;

    task automatic ev_push(input int b, input int x);
        if (b == 0) ev0.push_back(x);
        else        ev1.push_back(x);
    endtask

    function automatic int ev_size(input int b);
        return (b == 0) ? ev0.size() : ev1.size();
    endfunction

    function automatic int ev_at(input int b, input int i);
        return (b == 0) ? ev0[i] : ev1[i];
    endfunction

    task automatic mon_step();
        if (clear_req != clr_seen) begin
            clr_seen = clear_req;
            ev0.delete();
            ev1.delete();
            diffcnt = 0;
            for (int b = 0; b < 2; b++) begin
                lowcnt[b] = 0;
                bcnt[b]   = 0;
                word[b]   = 0;
            end
        end
        for (int b = 0; b < 2; b++) begin
            if (!SCLLINES[b] || !SDALINES[b]) lowcnt[b]++;
            if (p_scl[b] && SCLLINES[b] && p_sda[b] && !SDALINES[b]) begin
                ev_push(b, -1);
                bcnt[b] = 0;
                word[b] = 0;
            end else if (p_scl[b] && SCLLINES[b] && !p_sda[b] && SDALINES[b]) begin
                ev_push(b, -2);
                bcnt[b] = 0;
                word[b] = 0;
            end else if (!p_scl[b] && SCLLINES[b]) begin
                word[b] = (word[b] << 1) | int'(SDALINES[b]);
                bcnt[b]++;
                if (bcnt[b] == 9) begin
                    ev_push(b, word[b]);
                    bcnt[b] = 0;
                    word[b] = 0;
                end
            end
        end
        if (SCLLINES[0] != SCLLINES[1] || SDALINES[0] != SDALINES[1]) diffcnt++;
        if (DONE) done_cnt++;
        if (BUSY && !p_busy) busy_rise++;
        p_scl  = SCLLINES;
        p_sda  = SDALINES;
        p_busy = BUSY;
    endtask

    initial begin
        for (int b = 0; b < 2; b++) begin
            lowcnt[b] = 0;
            bcnt[b]   = 0;
            word[b]   = 0;
        end
        forever begin
            @(negedge clk_i);
            mon_step();
        end
    end

    // One frame; redge_at > 0 re-pulses ENABLE that many cycles into the frame.
    task automatic run_frame(input vec_t v, input int redge_at);
        int   w;
        int   cnt;
        int   d0;
        int   b0;
        int   nbytes;
        int   exp_ev[$];
        logic [7:0] bytes [4];
        ENABLE    = 1'b0;
        I2CLINES  = v.lines;
        I2CDATA12 = v.d12;
        I2CDATA34 = v.d34;
        SDAIN     = v.sdain;
        clear_req++;
        repeat (3) @(negedge clk_i);
        d0 = done_cnt;
        b0 = busy_rise;
        ENABLE = 1'b1;
        w = 0;
        while (!BUSY && w < 10) begin
            @(negedge clk_i);
            w++;
        end
        check("accept_busy", int'(BUSY), 1);
        check("accept_nack_clear", int'(NACK), 0);
        cnt = 0;
        while (!DONE && cnt < 2000) begin
            @(negedge clk_i);
            cnt++;
            if (redge_at > 0 && cnt == redge_at)     ENABLE = 1'b0;
            if (redge_at > 0 && cnt == redge_at + 2) ENABLE = 1'b1;
        end
        check("done_latency", cnt, v.exp_cycles);
        check("busy_at_done", int'(BUSY), 0);
        check("nack_at_done", int'(NACK), int'(v.exp_nack));
        @(negedge clk_i);
        check("done_one_cycle", int'(DONE), 0);
        repeat (20) @(negedge clk_i);
        check("done_count", done_cnt - d0, 1);
        check("busy_rise_count", busy_rise - b0, 1);

        bytes  = '{v.d12[15:8], v.d12[7:0], v.d34[15:8], v.d34[7:0]};
        nbytes = (ABORT && v.exp_nack) ? 1 : 4;
        exp_ev.push_back(-1);
        for (int k = 0; k < nbytes; k++) exp_ev.push_back((int'(bytes[k]) << 1) | 1);
        exp_ev.push_back(-2);
        for (int b = 0; b < 2; b++) begin
            if (v.lines[b]) begin
                check($sformatf("bus%0d_event_count", b), ev_size(b), exp_ev.size());
                for (int i = 0; i < exp_ev.size() && i < ev_size(b); i++)
                    check($sformatf("bus%0d_event%0d", b, i), ev_at(b, i), exp_ev[i]);
            end else begin
                check($sformatf("bus%0d_unselected_low_cycles", b), lowcnt[b], 0);
            end
        end
        if (v.lines == 2'b11) check("bus_waveforms_differ_cycles", diffcnt, 0);
        ENABLE = 1'b0;
    endtask

    vec_t vecs [10];

    initial begin
        int   w;
        int   d0;
        int   b0;
        logic [1:0] rs;

        vecs[0] = mk(2'b10, 16'hC040, 16'h7D00, 2'b00);
        vecs[1] = mk(2'b11, 16'h1234, 16'hABCD, 2'b01);
        vecs[2] = mk(2'b10, 16'h9E01, 16'h8000, 2'b11);
        vecs[3] = mk(2'b01, 16'h5500, 16'hAA0F, 2'b10);
        vecs[4] = mk(2'b11, 16'hFFFF, 16'hFFFF, 2'b00);
        for (int i = 5; i < 10; i++) begin
            rs = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            vecs[i] = mk(2'($urandom_range(1, 3)), 16'($urandom), 16'($urandom), rs);
        end

        rst_i     = 1'b1;
        ENABLE    = 1'b0;
        I2CLINES  = 2'b00;
        I2CDATA12 = 16'h0000;
        I2CDATA34 = 16'h0000;
        SDAIN     = 2'b00;
        #2 rst_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        check("reset_scl", int'(SCLLINES), 3);
        check("reset_sda", int'(SDALINES), 3);
        check("reset_busy", int'(BUSY), 0);
        check("reset_done", int'(DONE), 0);
        check("reset_nack", int'(NACK), 0);
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);

        for (int i = 0; i < 10; i++) run_frame(vecs[i], 0);

        // Second edge while busy is dropped.
        run_frame(vecs[0], 100);

        // Edge with no bus selected is ignored.
        ENABLE   = 1'b0;
        I2CLINES = 2'b00;
        repeat (3) @(negedge clk_i);
        d0 = done_cnt;
        b0 = busy_rise;
        ENABLE = 1'b1;
        repeat (30) @(negedge clk_i);
        check("nolines_busy_rise", busy_rise - b0, 0);
        check("nolines_done", done_cnt - d0, 0);
        ENABLE = 1'b0;

        // Reset during tick 50 (SCL low on bus1).
        I2CLINES  = 2'b10;
        I2CDATA12 = 16'h5A3C;
        I2CDATA34 = 16'h0F0F;
        SDAIN     = 2'b00;
        repeat (3) @(negedge clk_i);
        ENABLE = 1'b1;
        w = 0;
        while (!BUSY && w < 10) begin
            @(negedge clk_i);
            w++;
        end
        check("midrst_accept", int'(BUSY), 1);
        repeat (50 * CLK_DIV) @(negedge clk_i);
        check("midrst_pre_scl", int'(SCLLINES), 1);
        #2 rst_i = 1'b0;
        #1;
        check("midrst_scl", int'(SCLLINES), 3);
        check("midrst_sda", int'(SDALINES), 3);
        check("midrst_busy", int'(BUSY), 0);
        ENABLE = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        run_frame(vecs[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
